ifid_idex_exmem: RTL and testbench

IFID_IDEX_EXMEM -- requirements
Module: ifid_idex_exmem

---
 rtl/ifid_idex_exmem.sv | 198 +++++++++++++++++++
 tb/tb_ifid_idex_exmem.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_idex_exmem.sv
// Three independent pipeline registers: IF/ID, ID/EX and EX/MEM.
// Define PIPE_STALL_EN to honour stallD on IF/ID; otherwise stallD is ignored.
module ifid_idex_exmem #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            reset,
  // IF/ID
  input  logic [XLEN-1:0] insF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            stallD,
  input  logic            flushD,
  output logic [XLEN-1:0] insD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  // ID/EX
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] pcD,
  input  logic [XLEN-1:0] extImmD,
  input  logic [XLEN-1:0] PCPlus4D_in,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [4:0]      rdD,
  input  logic            regWriteD,
  input  logic            memWriteD,
  input  logic            jumpD,
  input  logic            branchD,
  input  logic            ALUsrcD,
  input  logic [3:0]      ALUcontrolD,
  input  logic [1:0]      ResultSrcD,
  input  logic            flushE,
  output logic [XLEN-1:0] rd1E,
  output logic [XLEN-1:0] rd2E,
  output logic [XLEN-1:0] pcE,
  output logic [XLEN-1:0] extImmE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      rs1E,
  output logic [4:0]      rs2E,
  output logic [4:0]      rdE,
  output logic            regWriteE,
  output logic            memWriteE,
  output logic            jumpE,
  output logic            branchE,
  output logic            ALUsrcE,
  output logic [3:0]      ALUcontrolE,
  output logic [1:0]      ResultSrcE,
  // EX/MEM
  input  logic [XLEN-1:0] aluResultE,
  input  logic [XLEN-1:0] writeDataE,
  input  logic [XLEN-1:0] PCPlus4E_in,
  input  logic [4:0]      rdE_in,
  input  logic            regWriteE_in,
  input  logic            memWriteE_in,
  input  logic [1:0]      ResultSrcE_in,
  output logic [XLEN-1:0] aluResultM,
  output logic [XLEN-1:0] writeDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      rdM,
  output logic            regWriteM,
  output logic            memWriteM,
  output logic [1:0]      ResultSrcM
);

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [3:0]      alu_ctrl;
    logic [1:0]      result_src;
  } idex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
  } exmem_t;

  ifid_t  ifid_d,  ifid_q;
  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;
  logic   stall_c;

`ifdef PIPE_STALL_EN
  assign stall_c = stallD;
`else
  logic stall_unused;
  assign stall_c      = 1'b0;
  assign stall_unused = stallD;
`endif

  // IF/ID next state: flush outranks stall
  always_comb begin
    ifid_d = ifid_q;
    if (flushD) begin
      ifid_d = '0;
    end else if (!stall_c) begin
      ifid_d.ins = insF;
      ifid_d.pc  = PCF;
      ifid_d.pc4 = PCPlus4F;
    end
  end

  // ID/EX next state: flushE inserts an all-zero bubble
  always_comb begin
    idex_d = '0;
    if (!flushE) begin
      idex_d.rd1        = rd1;
      idex_d.rd2        = rd2;
      idex_d.pc         = pcD;
      idex_d.imm        = extImmD;
      idex_d.pc4        = PCPlus4D_in;
      idex_d.rs1        = rs1D;
      idex_d.rs2        = rs2D;
      idex_d.rd         = rdD;
      idex_d.reg_write  = regWriteD;
      idex_d.mem_write  = memWriteD;
      idex_d.jump       = jumpD;
      idex_d.branch     = branchD;
      idex_d.alu_src    = ALUsrcD;
      idex_d.alu_ctrl   = ALUcontrolD;
      idex_d.result_src = ResultSrcD;
    end
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.alu_result = aluResultE;
    exmem_d.write_data = writeDataE;
    exmem_d.pc4        = PCPlus4E_in;
    exmem_d.rd         = rdE_in;
    exmem_d.reg_write  = regWriteE_in;
    exmem_d.mem_write  = memWriteE_in;
    exmem_d.result_src = ResultSrcE_in;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign insD        = ifid_q.ins;
  assign PCD         = ifid_q.pc;
  assign PCPlus4D    = ifid_q.pc4;

  assign rd1E        = idex_q.rd1;
  assign rd2E        = idex_q.rd2;
  assign pcE         = idex_q.pc;
  assign extImmE     = idex_q.imm;
  assign PCPlus4E    = idex_q.pc4;
  assign rs1E        = idex_q.rs1;
  assign rs2E        = idex_q.rs2;
  assign rdE         = idex_q.rd;
  assign regWriteE   = idex_q.reg_write;
  assign memWriteE   = idex_q.mem_write;
  assign jumpE       = idex_q.jump;
  assign branchE     = idex_q.branch;
  assign ALUsrcE     = idex_q.alu_src;
  assign ALUcontrolE = idex_q.alu_ctrl;
  assign ResultSrcE  = idex_q.result_src;

  assign aluResultM  = exmem_q.alu_result;
  assign writeDataM  = exmem_q.write_data;
  assign PCPlus4M    = exmem_q.pc4;
  assign rdM         = exmem_q.rd;
  assign regWriteM   = exmem_q.reg_write;
  assign memWriteM   = exmem_q.mem_write;
  assign ResultSrcM  = exmem_q.result_src;

endmodule

// File: tb/tb_ifid_idex_exmem.sv
// Scoreboard bench for ifid_idex_exmem: directed scenarios plus random traffic
// checked against a per-stage behavioural model.
module tb_ifid_idex_exmem;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IFW  = 3 * XLEN;
  localparam int unsigned IDW  = 5 * XLEN + 15 + 5 + 4 + 2;
  localparam int unsigned EXW  = 3 * XLEN + 5 + 1 + 1 + 2;
`ifdef PIPE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic CLK;
  logic reset;
  logic [XLEN-1:0] insF, PCF, PCPlus4F;
  logic stallD, flushD;
  logic [XLEN-1:0] insD, PCD, PCPlus4D;
  logic [XLEN-1:0] rd1, rd2, pcD, extImmD, PCPlus4D_in;
  logic [4:0] rs1D, rs2D, rdD;
  logic regWriteD, memWriteD, jumpD, branchD, ALUsrcD;
  logic [3:0] ALUcontrolD;
  logic [1:0] ResultSrcD;
  logic flushE;
  logic [XLEN-1:0] rd1E, rd2E, pcE, extImmE, PCPlus4E;
  logic [4:0] rs1E, rs2E, rdE;
  logic regWriteE, memWriteE, jumpE, branchE, ALUsrcE;
  logic [3:0] ALUcontrolE;
  logic [1:0] ResultSrcE;
  logic [XLEN-1:0] aluResultE, writeDataE, PCPlus4E_in;
  logic [4:0] rdE_in;
  logic regWriteE_in, memWriteE_in;
  logic [1:0] ResultSrcE_in;
  logic [XLEN-1:0] aluResultM, writeDataM, PCPlus4M;
  logic [4:0] rdM;
  logic regWriteM, memWriteM;
  logic [1:0] ResultSrcM;

  ifid_idex_exmem #(.XLEN(XLEN)) dut (
    .CLK(CLK), .reset(reset),
    .insF(insF), .PCF(PCF), .PCPlus4F(PCPlus4F), .stallD(stallD), .flushD(flushD),
    .insD(insD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .rd1(rd1), .rd2(rd2), .pcD(pcD), .extImmD(extImmD), .PCPlus4D_in(PCPlus4D_in),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .regWriteD(regWriteD), .memWriteD(memWriteD), .jumpD(jumpD), .branchD(branchD),
    .ALUsrcD(ALUsrcD), .ALUcontrolD(ALUcontrolD), .ResultSrcD(ResultSrcD), .flushE(flushE),
    .rd1E(rd1E), .rd2E(rd2E), .pcE(pcE), .extImmE(extImmE), .PCPlus4E(PCPlus4E),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .jumpE(jumpE), .branchE(branchE),
    .ALUsrcE(ALUsrcE), .ALUcontrolE(ALUcontrolE), .ResultSrcE(ResultSrcE),
    .aluResultE(aluResultE), .writeDataE(writeDataE), .PCPlus4E_in(PCPlus4E_in),
    .rdE_in(rdE_in), .regWriteE_in(regWriteE_in), .memWriteE_in(memWriteE_in),
    .ResultSrcE_in(ResultSrcE_in),
    .aluResultM(aluResultM), .writeDataM(writeDataM), .PCPlus4M(PCPlus4M), .rdM(rdM),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .ResultSrcM(ResultSrcM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [IFW-1:0] ifid;
    logic [IDW-1:0] idex;
    logic [EXW-1:0] exmem;
  } exp_t;

  exp_t sb[$];
  logic [IFW-1:0] m_ifid;
  logic [IDW-1:0] m_idex;
  logic [EXW-1:0] m_exmem;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Model: each stage's visible value after the coming edge, from its own inputs only
  task automatic tick();
    exp_t e;
    if (reset) begin
      m_ifid  = '0;
      m_idex  = '0;
      m_exmem = '0;
    end else begin
      if (flushD) m_ifid = '0;
      else if (!(STALL_EN && stallD)) m_ifid = {insF, PCF, PCPlus4F};
      m_idex = flushE ? '0 : {rd1, rd2, pcD, extImmD, PCPlus4D_in, rs1D, rs2D, rdD,
                              regWriteD, memWriteD, jumpD, branchD, ALUsrcD,
                              ALUcontrolD, ResultSrcD};
      m_exmem = {aluResultE, writeDataE, PCPlus4E_in, rdE_in, regWriteE_in,
                 memWriteE_in, ResultSrcE_in};
    end
    e.ifid  = m_ifid;
    e.idex  = m_idex;
    e.exmem = m_exmem;
    sb.push_back(e);
    @(negedge CLK);
  endtask

  task automatic rand_inputs();
    insF = $urandom; PCF = $urandom & 32'hFFFF_FFFC; PCPlus4F = PCF + 32'd4;
    stallD = ($urandom_range(0, 3) == 0);
    flushD = ($urandom_range(0, 7) == 0);
    rd1 = $urandom; rd2 = $urandom; pcD = $urandom; extImmD = $urandom;
    PCPlus4D_in = $urandom;
    rs1D = 5'($urandom); rs2D = 5'($urandom); rdD = 5'($urandom);
    regWriteD = 1'($urandom); memWriteD = 1'($urandom); jumpD = 1'($urandom);
    branchD = 1'($urandom); ALUsrcD = 1'($urandom);
    ALUcontrolD = 4'($urandom); ResultSrcD = 2'($urandom);
    flushE = ($urandom_range(0, 7) == 0);
    aluResultE = $urandom; writeDataE = $urandom; PCPlus4E_in = $urandom;
    rdE_in = 5'($urandom); regWriteE_in = 1'($urandom); memWriteE_in = 1'($urandom);
    ResultSrcE_in = 2'($urandom);
  endtask

  // Monitor: every edge presents a new value on all three stages
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_ifid", 256'({insD, PCD, PCPlus4D}), 256'(e.ifid));
        chk("sb_idex", 256'({rd1E, rd2E, pcE, extImmE, PCPlus4E, rs1E, rs2E, rdE,
                             regWriteE, memWriteE, jumpE, branchE, ALUsrcE,
                             ALUcontrolE, ResultSrcE}), 256'(e.idex));
        chk("sb_exmem", 256'({aluResultM, writeDataM, PCPlus4M, rdM, regWriteM,
                              memWriteM, ResultSrcM}), 256'(e.exmem));
      end
    end
  end

  initial begin
    // Reset with every input driven high
    reset = 1'b1;
    insF = '1; PCF = '1; PCPlus4F = '1; stallD = 1'b1; flushD = 1'b1;
    rd1 = '1; rd2 = '1; pcD = '1; extImmD = '1; PCPlus4D_in = '1;
    rs1D = '1; rs2D = '1; rdD = '1;
    regWriteD = 1'b1; memWriteD = 1'b1; jumpD = 1'b1; branchD = 1'b1; ALUsrcD = 1'b1;
    ALUcontrolD = '1; ResultSrcD = '1; flushE = 1'b1;
    aluResultE = '1; writeDataE = '1; PCPlus4E_in = '1; rdE_in = '1;
    regWriteE_in = 1'b1; memWriteE_in = 1'b1; ResultSrcE_in = '1;
    #1;
    tick();
    tick();
    chk("rst_insD", 256'(insD), 256'(0));
    chk("rst_rd1E", 256'(rd1E), 256'(0));
    chk("rst_regWriteE", 256'(regWriteE), 256'(0));
    chk("rst_aluResultM", 256'(aluResultM), 256'(0));
    chk("rst_regWriteM", 256'(regWriteM), 256'(0));

    // First load through IF/ID
    reset = 1'b0;
    rand_inputs();
    stallD = 1'b0; flushD = 1'b0; flushE = 1'b0;
    insF = 32'h0050_0293; PCF = 32'h8; PCPlus4F = 32'hC;
    tick();
    chk("load_insD", 256'(insD), 256'(32'h0050_0293));
    chk("load_PCD", 256'(PCD), 256'(32'h8));
    chk("load_PCPlus4D", 256'(PCPlus4D), 256'(32'hC));

    // Stall holds for three edges (ignored when the stall feature is off)
    for (int i = 0; i < 3; i++) begin
      stallD = 1'b1;
      insF = 32'h1000_0000 + 32'(i);
      tick();
      chk("stall_insD", 256'(insD), STALL_EN ? 256'(32'h0050_0293) : 256'(32'h1000_0000 + 32'(i)));
    end
    flushD = 1'b1;
    tick();
    chk("flush_over_stall_insD", 256'(insD), 256'(0));
    stallD = 1'b0; flushD = 1'b0;

    // ID/EX bubble, then reload
    flushE = 1'b1; regWriteD = 1'b1; memWriteD = 1'b1; ALUcontrolD = 4'h5; rd1 = 32'h1234;
    tick();
    chk("bubble_regWriteE", 256'(regWriteE), 256'(0));
    chk("bubble_memWriteE", 256'(memWriteE), 256'(0));
    chk("bubble_ALUcontrolE", 256'(ALUcontrolE), 256'(0));
    chk("bubble_rd1E", 256'(rd1E), 256'(0));
    flushE = 1'b0;
    tick();
    chk("reload_rd1E", 256'(rd1E), 256'(32'h1234));
    chk("reload_ALUcontrolE", 256'(ALUcontrolE), 256'(4'h5));

    // EX/MEM ignores every flush/stall control
    aluResultE = 32'hDEAD_BEEF; rdE_in = 5'd9; regWriteE_in = 1'b1;
    flushE = 1'b1; flushD = 1'b1; stallD = 1'b1;
    tick();
    chk("exmem_aluResultM", 256'(aluResultM), 256'(32'hDEAD_BEEF));
    chk("exmem_rdM", 256'(rdM), 256'(5'd9));
    chk("exmem_regWriteM", 256'(regWriteM), 256'(1));

    // Random traffic, with a mid-run reset
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      tick();
    end
    rand_inputs();
    reset = 1'b1;
    tick();
    chk("midrst_insD", 256'(insD), 256'(0));
    chk("midrst_rdE", 256'(rdE), 256'(0));
    chk("midrst_writeDataM", 256'(writeDataM), 256'(0));
    reset = 1'b0;
    rand_inputs();
    aluResultE = 32'h0000_0055;
    tick();
    chk("postrst_aluResultM", 256'(aluResultM), 256'(32'h55));
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      tick();
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain pending=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
